// File: rtl/stream_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_serializer_if
// Purpose  : Handshake bundle for stream_serializer. It carries a wide input
//            word stream and a narrow output element stream.
// Ports    : data_in[DATA_WIDTH*NUM_ELEMS] / data_in_valid / data_in_ready
//            form the word input handshake.
//            data_out[DATA_WIDTH] / data_out_valid / data_out_ready /
//            data_out_last form the element output handshake.
// Modports : master - the producer/consumer side, such as a testbench or
//                     the surrounding logic
//            slave  - the serializer side
// Revision : 1.0 - initial release
// ============================================================================
interface stream_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELEMS  = 4
);
  logic [DATA_WIDTH*NUM_ELEMS-1:0] data_in;
  logic                            data_in_valid;
  logic                            data_in_ready;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            data_out_valid;
  logic                            data_out_ready;
  logic                            data_out_last;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last
  );
endinterface
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : stream_serializer
// Purpose  : Accepts a word of NUM_ELEMS packed elements and emits it one
//            element per cycle, with element 0 in the low bits emitted first.
//            Latency is one cycle. When the last element handshakes, a new
//            word can be loaded with no bubble between the two words.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-low reset
//            bus - stream_serializer_if.slave, which holds the word input
//                  handshake and the element output handshake
// Revision : 1.0 - initial release
// ============================================================================
module stream_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELEMS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_serializer_if.slave   bus
);

  localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]                           state;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0]                elem;

  logic busy;
  logic at_last;
  logic in_hs;
  logic out_hs;

  assign busy    = (state == ST_BUSY);
  assign at_last = (idx == LAST_IDX);
  assign out_hs  = busy && bus.data_out_ready;
  assign in_hs   = bus.data_in_valid && bus.data_in_ready;

  // Ready depends only on state and on downstream ready. It never depends
  // on data_in_valid, so no valid-to-ready loop can form upstream.
  assign bus.data_in_ready  = (state == ST_IDLE) || (at_last && bus.data_out_ready);
  assign bus.data_out_valid = busy;
  assign bus.data_out_last  = busy && at_last;
  assign bus.data_out       = elem;

  // The element is selected by an explicit compare instead of a variable
  // part-select. idx is only ever compared against legal element numbers,
  // so non-power-of-two NUM_ELEMS needs no special handling.
  always_comb begin
    elem = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (idx == IDX_W'(k)) begin
        elem = word[k];
      end
    end
  end

  // An input handshake in BUSY can only happen together with the output
  // handshake of the last element, so the load branch also covers the
  // back-to-back case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      word  <= '0;
    end else if (in_hs) begin
      word  <= bus.data_in;
      idx   <= '0;
      state <= ST_BUSY;
    end else if (out_hs) begin
      if (at_last) begin
        idx   <= '0;
        state <= ST_IDLE;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stream_serializer
// Purpose  : Self-checking bench for stream_serializer. It instantiates three
//            configurations: NUM_ELEMS = 4, 1 and 3, all with 8-bit elements.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  stream_serializer_if #(.DATA_WIDTH(8), .NUM_ELEMS(4)) if4 ();
  stream_serializer_if #(.DATA_WIDTH(8), .NUM_ELEMS(1)) if1 ();
  stream_serializer_if #(.DATA_WIDTH(8), .NUM_ELEMS(3)) if3 ();

  stream_serializer #(.DATA_WIDTH(8), .NUM_ELEMS(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  stream_serializer #(.DATA_WIDTH(8), .NUM_ELEMS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  stream_serializer #(.DATA_WIDTH(8), .NUM_ELEMS(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive the NUM_ELEMS=4 instance at the falling edge, then let the
  // combinational outputs settle before they are sampled.
  task automatic drive4(input logic iv, input logic [31:0] din, input logic ordy);
    @(negedge clk);
    if4.data_in_valid  = iv;
    if4.data_in        = din;
    if4.data_out_ready = ordy;
    #1;
  endtask

  task automatic chk4(input string tag, input logic e_ir, input logic e_ov,
                      input logic [7:0] e_out, input logic e_last);
    chk_bit({tag, "_in_ready"}, if4.data_in_ready, e_ir);
    chk_bit({tag, "_out_valid"}, if4.data_out_valid, e_ov);
    if (e_ov) chk_byte({tag, "_data_out"}, if4.data_out, e_out);
    chk_bit({tag, "_last"}, if4.data_out_last, e_last);
  endtask

  // Random traffic checked against a queue of expected elements. A word
  // pushes all of its elements at once, and each output handshake pops one
  // element. The remaining count is simply the queue size.
  task automatic run_random(input int ne, input int nwords);
    logic [7:0]  q[$];
    int          accepted = 0;
    int          emitted  = 0;
    int          cyc      = 0;
    logic        iv, ordy, e_ir, ov, last, ir;
    logic [7:0]  dout;
    logic [23:0] w;
    string       tag;
    tag = $sformatf("rand_ne%0d", ne);
    while ((accepted < nwords || q.size() > 0) && cyc < 3000) begin
      iv   = (accepted < nwords) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ordy = (ne == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
      w    = 24'($urandom);
      @(negedge clk);
      if (ne == 1) begin
        if1.data_in_valid = iv; if1.data_in = w[7:0]; if1.data_out_ready = ordy;
      end else begin
        if3.data_in_valid = iv; if3.data_in = w; if3.data_out_ready = ordy;
      end
      #1;
      if (ne == 1) begin
        ov = if1.data_out_valid; last = if1.data_out_last; ir = if1.data_in_ready; dout = if1.data_out;
      end else begin
        ov = if3.data_out_valid; last = if3.data_out_last; ir = if3.data_in_ready; dout = if3.data_out;
      end
      e_ir = (q.size() == 0) || (q.size() == 1 && ordy);
      chk_bit({tag, "_in_ready"}, ir, e_ir);
      chk_bit({tag, "_out_valid"}, ov, q.size() > 0);
      if (q.size() > 0) begin
        chk_byte({tag, "_data_out"}, dout, q[0]);
        chk_bit({tag, "_last"}, last, q.size() == 1);
      end
      if (ne == 1) chk_bit({tag, "_last_eq_valid"}, last, ov);
      if (q.size() > 0 && ordy) begin
        void'(q.pop_front());
        emitted++;
      end
      if (iv && e_ir) begin
        for (int k = 0; k < ne; k++) q.push_back(w[k*8 +: 8]);
        accepted++;
      end
      cyc++;
    end
    if (ne == 1) if1.data_in_valid = 1'b0;
    else         if3.data_in_valid = 1'b0;
    chk_int({tag, "_words_accepted"}, accepted, nwords);
    chk_int({tag, "_elems_emitted"}, emitted, nwords * ne);
    chk_int({tag, "_queue_drained"}, q.size(), 0);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_out;
    logic        e_last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Single word followed by a back-to-back second word. The values
    // starting at the reset state are listed in cycle order.
    vecs[0] = '{1'b1, 32'h44332211, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[2] = '{1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[3] = '{1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    vecs[4] = '{1'b1, 32'h88776655, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1};
    vecs[5] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[6] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    vecs[7] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
    vecs[8] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h88, 1'b1};
    vecs[9] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    if4.data_in_valid = 1'b0; if4.data_in = '0; if4.data_out_ready = 1'b0;
    if1.data_in_valid = 1'b0; if1.data_in = '0; if1.data_out_ready = 1'b0;
    if3.data_in_valid = 1'b0; if3.data_in = '0; if3.data_out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk4("reset", 1'b1, 1'b0, 8'h00, 1'b0);
    chk_byte("reset_data_out", if4.data_out, 8'h00);
    chk_bit("reset_ne1_valid", if1.data_out_valid, 1'b0);
    chk_bit("reset_ne3_valid", if3.data_out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      drive4(vecs[i].iv, vecs[i].din, vecs[i].ordy);
      chk4($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_out, vecs[i].e_last);
    end

    // Backpressure while 0x22 is presented. The offered word must not be
    // taken during the stall.
    drive4(1'b1, 32'h44332211, 1'b1);
    drive4(1'b0, 32'h0, 1'b1);
    chk4("bp_e0", 1'b0, 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 32'hdeadbeef, 1'b0);
      chk4($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 8'h22, 1'b0);
    end
    drive4(1'b1, 32'hdeadbeef, 1'b1);
    chk4("bp_release", 1'b0, 1'b1, 8'h22, 1'b0);
    drive4(1'b0, 32'h0, 1'b1);
    chk4("bp_e2", 1'b0, 1'b1, 8'h33, 1'b0);
    drive4(1'b0, 32'h0, 1'b1);
    chk4("bp_e3", 1'b1, 1'b1, 8'h44, 1'b1);
    drive4(1'b0, 32'h0, 1'b1);
    chk4("bp_idle", 1'b1, 1'b0, 8'h00, 1'b0);

    // Mid-word reset after 0x22 has been emitted
    drive4(1'b1, 32'h44332211, 1'b1);
    drive4(1'b0, 32'h0, 1'b1);
    chk4("mr_e0", 1'b0, 1'b1, 8'h11, 1'b0);
    drive4(1'b0, 32'h0, 1'b1);
    chk4("mr_e1", 1'b0, 1'b1, 8'h22, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk4("mr_in_reset", 1'b1, 1'b0, 8'h00, 1'b0);
    chk_byte("mr_reset_data_out", if4.data_out, 8'h00);
    @(negedge clk);
    #1;
    chk4("mr_held_reset", 1'b1, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    drive4(1'b1, 32'hddccbbaa, 1'b1);
    chk4("mr_after_release", 1'b1, 1'b0, 8'h00, 1'b0);
    begin
      logic [31:0] nw;
      nw = 32'hddccbbaa;
      for (int k = 0; k < 4; k++) begin
        drive4(1'b0, 32'h0, 1'b1);
        chk4($sformatf("mr_new_e%0d", k), k == 3, 1'b1, nw[k*8 +: 8], k == 3);
      end
    end
    drive4(1'b0, 32'h0, 1'b1);
    chk4("mr_final_idle", 1'b1, 1'b0, 8'h00, 1'b0);

    // Randomized traffic against the queue model
    run_random(1, 100);
    run_random(3, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
